// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver, LSB first, idle-high line.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (4..65535), default 104
//
// Ports:
//   clk          single clock, rising-edge
//   reset        asynchronous, active-high
//   rx           asynchronous serial input
//   data_rx      last correctly framed byte (held between frames)
//   data_rx_seq  toggles once per new byte in data_rx
//   frame_err    set when the last frame had a low stop bit; cleared by next good frame
//   busy         registered, high whenever the receiver is not idle
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_rx,
  output logic       data_rx_seq,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t          state, state_n;
  logic            rx_meta, rxs;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shreg, shreg_n;
  logic [7:0]      data_n;
  logic            seq_n, ferr_n, busy_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      data_rx     <= '0;
      data_rx_seq <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rxs         <= rx_meta;
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shreg       <= shreg_n;
      data_rx     <= data_n;
      data_rx_seq <= seq_n;
      frame_err   <= ferr_n;
      busy        <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data_rx;
    seq_n   = data_rx_seq;
    ferr_n  = frame_err;

    if (state == IDLE) begin
      if (!rxs) begin
        // Half-bit delay lands the first sample in the middle of the start bit.
        state_n = START;
        cnt_n   = HALF_M1;
      end
    end else if (cnt != '0) begin
      cnt_n = cnt - CW'(1);
    end else begin
      case (state)
        START: begin
          if (rxs) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            cnt_n   = FULL_M1;
            idx_n   = '0;
          end
        end
        DATA: begin
          shreg_n = {rxs, shreg[7:1]};
          cnt_n   = FULL_M1;
          if (idx == 3'd7) begin
            state_n = STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
        STOP: begin
          if (rxs) begin
            data_n  = shreg;
            seq_n   = ~data_rx_seq;
            ferr_n  = 1'b0;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end
        BREAK: begin
          // Counter is already zero here; wait for the line to return high.
          if (rxs) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int unsigned C = 8;
  // detect is 3 edges after the pin falls, stop sample is 76 edges after detect
  localparam int unsigned TOGGLE_LAT = 3 + C / 2 + 9 * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data_rx;
  logic       data_rx_seq;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_rx    (data_rx),
    .data_rx_seq(data_rx_seq),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;
  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every data_rx_seq toggle must match the next queued frame.
  logic seq_prev = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (reset) begin
      seq_prev = data_rx_seq;
    end else if (data_rx_seq !== seq_prev) begin
      seq_prev = data_rx_seq;
      check("toggle_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_data", 32'(data_rx), 32'(e.data));
        check("sb_toggle_cycle", cyc, e.cyc);
        check("sb_frame_err", 32'(frame_err), 32'd0);
      end
    end
  end

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_cyc(C);
  endtask

  // Sends start + 8 data bits + stop; leaves rx at the stop value.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic expect_good);
    exp_t x;
    if (expect_good) begin
      x.data = d;
      x.cyc  = cyc + TOGGLE_LAT;
      sb.push_back(x);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  initial begin
    logic [7:0] b81;
    b81 = 8'h81;

    // Reset state
    wait_cyc(3);
    check("rst_data", 32'(data_rx), 32'h00);
    check("rst_seq", 32'(data_rx_seq), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    wait_cyc(4);

    // Good frame 0xA5
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_cyc(4);
    check("a5_data", 32'(data_rx), 32'hA5);
    check("a5_seq", 32'(data_rx_seq), 32'd1);
    check("a5_ferr", 32'(frame_err), 32'd0);
    check("a5_busy", 32'(busy), 32'd0);

    // False start: 3 low cycles
    rx = 1'b0;
    wait_cyc(3);
    check("fs_busy_during", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_cyc(8);
    check("fs_busy_after", 32'(busy), 32'd0);
    check("fs_data", 32'(data_rx), 32'hA5);
    check("fs_seq", 32'(data_rx_seq), 32'd1);

    // Framing error then held-low break, then recovery frame
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_cyc(40);
    check("brk_ferr", 32'(frame_err), 32'd1);
    check("brk_busy", 32'(busy), 32'd1);
    check("brk_seq", 32'(data_rx_seq), 32'd1);
    check("brk_data", 32'(data_rx), 32'hA5);
    rx = 1'b1;
    wait_cyc(5);
    check("brk_end_busy", 32'(busy), 32'd0);
    check("brk_end_ferr", 32'(frame_err), 32'd1);
    send_frame(8'h5A, 1'b1, 1'b1);
    wait_cyc(4);
    check("5a_data", 32'(data_rx), 32'h5A);
    check("5a_seq", 32'(data_rx_seq), 32'd0);
    check("5a_ferr", 32'(frame_err), 32'd0);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    wait_cyc(4);
    check("b2b_data", 32'(data_rx), 32'hFF);
    check("b2b_seq", 32'(data_rx_seq), 32'd0);
    check("b2b_busy", 32'(busy), 32'd0);

    // Reset during bit 4 of 0x81
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b81[i]);
    rx = b81[4];
    wait_cyc(4);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mr_data", 32'(data_rx), 32'h00);
    check("mr_seq", 32'(data_rx_seq), 32'd0);
    check("mr_ferr", 32'(frame_err), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(4);
    check("post_rst_busy", 32'(busy), 32'd0);
    send_frame(8'h42, 1'b1, 1'b1);
    wait_cyc(4);
    check("42_data", 32'(data_rx), 32'h42);
    check("42_seq", 32'(data_rx_seq), 32'd1);

    wait_cyc(10);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
